input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Front-end conditioning stage directly upstream of the controller's Synchronizer.
- Cleans the three raw push-button/sensor pins: Sensor, Walk_Request and Reprogram.
- Each channel gets a 2-flop metastability synchronizer and a per-channel debounce state machine.
- Each channel outputs a stable level plus a one-cycle rising-edge pulse. The walk register and reprogram path see exactly one event per physical press.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz). Must be at least 2.
- CNT_W, 19, width of each channel counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clock  in  1  system clock. Everything is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Sensor_Raw  in  1  asynchronous raw vehicle sensor pin.
- Walk_Request_Raw  in  1  asynchronous raw pedestrian button.
- Reprogram_Raw  in  1  asynchronous raw reprogram button.
- Sensor_Clean  out  1  debounced Sensor level.
- Walk_Request_Clean  out  1  debounced Walk_Request level.
- Reprogram_Clean  out  1  debounced Reprogram level.
- Sensor_Pulse  out  1  one-cycle pulse on an accepted Sensor rise.
- Walk_Request_Pulse  out  1  one-cycle pulse on an accepted Walk_Request rise.
- Reprogram_Pulse  out  1  one-cycle pulse on an accepted Reprogram rise.
- Glitch_Count  out  8  rejected-transition count. Present only with DEBOUNCE_GLITCH_CNT_EN.

Behaviour:
- Clocking and reset: one clock, clock. Reset is synchronous and active-high. All registers update only on the rising edge of clock.
- Reset values: both synchronizer flops 0, all states STABLE_LOW, all counters 0, every Clean and Pulse output 0, Glitch_Count 0.
- Channel independence: the three channels are identical and independent. Rules below are per channel. "sync" is the output of the second synchronizer flop.
- Synchronizer: raw sampled high at edge k gives sync=1 after edge k+1.
- State machine states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- STABLE_LOW: if sync=1, go to WAIT_HIGH and set cnt=0. Otherwise hold. Clean=0.
- WAIT_HIGH, sync=0: glitch. Return to STABLE_LOW, set cnt=0, raise a glitch event.
- WAIT_HIGH, sync=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HIGH, set Clean<=1, set Pulse<=1.
- WAIT_HIGH, sync=1 otherwise: cnt<=cnt+1.
- STABLE_HIGH: if sync=0, go to WAIT_LOW and set cnt=0. Clean=1.
- WAIT_LOW: mirror of WAIT_HIGH with polarity inverted. Completion goes to STABLE_LOW with Clean<=0 and no pulse. An abort returns to STABLE_HIGH with a glitch event.
- Clean is unchanged throughout WAIT_* states.
- Pulse timing: Pulse is high for exactly one cycle, coincident with the first cycle Clean=1. Pulse is never high in any other cycle. Release never pulses.
- Latency: raw first sampled high at edge k and held gives Clean and Pulse high after edge k+DEBOUNCE_CYCLES+2. Release latency is identical.
- Counter: never exceeds DEBOUNCE_CYCLES-1 and never wraps. It is cleared on every WAIT_* entry and exit.
- Bounce shorter than the window: any input pulse whose synchronized width is at most DEBOUNCE_CYCLES cycles is fully rejected.
- Reset mid-debounce: the in-progress count is discarded and all outputs drop to 0 on the reset edge.
- Input held high across reset release: the full debounce restarts and then yields exactly one Pulse.
- Simultaneous events: channels may accept or pulse in the same cycle with no interaction.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Glitch_Count[7:0] exists.
  - Each cycle it adds the number of channels (0–3) raising a glitch event.
  - It saturates at 255 and never wraps.
  - It is cleared only by Reset.
- Undefined:
  - The port and its counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Clean press (DEBOUNCE_CYCLES=8): Walk_Request_Raw rises and is first sampled at edge 10, then held -> Walk_Request_Clean=1 and Walk_Request_Pulse=1 after edge 20 only. Pulse=0 after edge 21.
- Bounce rejection (DEBOUNCE_CYCLES=8): Sensor_Raw toggles high 3 cycles / low 2 cycles, five times, then stays low -> Sensor_Clean and Sensor_Pulse stay 0 throughout. Glitch_Count=5 if the macro is defined.
- Bouncy press then hold (DEBOUNCE_CYCLES=8): 4 short glitches followed by a steady high -> exactly one Reprogram_Pulse, 10 cycles after the final steady sample. Clean stays high.
- Release glitch (DEBOUNCE_CYCLES=8): from STABLE_HIGH, a 4-cycle low dip -> Clean stays 1 and no Pulse. A later 12-cycle low -> Clean=0, 10 cycles after the first low sample.
- Reset mid-debounce (DEBOUNCE_CYCLES=8): assert Reset at cnt=5 with raw still high, then deassert -> outputs 0 during reset. One Pulse follows 10 cycles after the first post-reset sample.
- Simultaneous channels (DEBOUNCE_CYCLES=8): all three raw inputs rise on the same edge -> all three Pulses are high in the same single cycle. With the macro defined, three glitches in one cycle add 3 to Glitch_Count. Preset near 254, the counter saturates at 255.

Source files
------------

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - three-channel synchronizer + debounce FSM with rise pulses.
// Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating rejected-transition counter.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Sensor_Raw,
  input  logic       Walk_Request_Raw,
  input  logic       Reprogram_Raw,
  output logic       Sensor_Clean,
  output logic       Walk_Request_Clean,
  output logic       Reprogram_Clean,
  output logic       Sensor_Pulse,
  output logic       Walk_Request_Pulse,
  output logic       Reprogram_Pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] Glitch_Count
`endif
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       raw;
  logic [2:0]       sync1, sync2;
  logic [2:0]       clean, clean_next;
  logic [2:0]       pulse, pulse_next;
  logic [2:0]       glitch;
  state_t           state      [3];
  state_t           state_next [3];
  logic [CNT_W-1:0] cnt        [3];
  logic [CNT_W-1:0] cnt_next   [3];

  assign raw = {Reprogram_Raw, Walk_Request_Raw, Sensor_Raw};

  always_ff @(posedge clock) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
      clean <= '0;
      pulse <= '0;
      for (int i = 0; i < 3; i++) begin
        state[i] <= STABLE_LOW;
        cnt[i]   <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      clean <= clean_next;
      pulse <= pulse_next;
      for (int i = 0; i < 3; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
    end
  end

  // Pulse is only set on the WAIT_HIGH completion, so it lines up with the first Clean=1 cycle.
  always_comb begin
    clean_next = clean;
    pulse_next = '0;
    glitch     = '0;
    for (int i = 0; i < 3; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      case (state[i])
        STABLE_LOW: begin
          if (sync2[i]) begin
            state_next[i] = WAIT_HIGH;
            cnt_next[i]   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2[i]) begin
            state_next[i] = STABLE_LOW;
            cnt_next[i]   = '0;
            glitch[i]     = 1'b1;
          end else if (cnt[i] == LAST) begin
            state_next[i] = STABLE_HIGH;
            cnt_next[i]   = '0;
            clean_next[i] = 1'b1;
            pulse_next[i] = 1'b1;
          end else begin
            cnt_next[i] = cnt[i] + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!sync2[i]) begin
            state_next[i] = WAIT_LOW;
            cnt_next[i]   = '0;
          end
        end
        WAIT_LOW: begin
          if (sync2[i]) begin
            state_next[i] = STABLE_HIGH;
            cnt_next[i]   = '0;
            glitch[i]     = 1'b1;
          end else if (cnt[i] == LAST) begin
            state_next[i] = STABLE_LOW;
            cnt_next[i]   = '0;
            clean_next[i] = 1'b0;
          end else begin
            cnt_next[i] = cnt[i] + 1'b1;
          end
        end
        default: begin
          state_next[i] = STABLE_LOW;
          cnt_next[i]   = '0;
        end
      endcase
    end
  end

  assign Sensor_Clean       = clean[0];
  assign Walk_Request_Clean = clean[1];
  assign Reprogram_Clean    = clean[2];
  assign Sensor_Pulse       = pulse[0];
  assign Walk_Request_Pulse = pulse[1];
  assign Reprogram_Pulse    = pulse[2];

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [8:0] glitch_sum;

  always_comb begin
    glitch_sum = {1'b0, Glitch_Count} + 9'(glitch[0]) + 9'(glitch[1]) + 9'(glitch[2]);
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      Glitch_Count <= '0;
    end else if (glitch_sum > 9'd255) begin
      Glitch_Count <= 8'd255;
    end else begin
      Glitch_Count <= glitch_sum[7:0];
    end
  end
`else
  logic unused_glitch;
  assign unused_glitch = ^glitch;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - randomized and directed bench against a run-length reference model.
module tb_input_debouncer;

  localparam int D = 8;

  logic clock = 1'b0;
  logic Reset, Sensor_Raw, Walk_Request_Raw, Reprogram_Raw;
  logic Sensor_Clean, Walk_Request_Clean, Reprogram_Clean;
  logic Sensor_Pulse, Walk_Request_Pulse, Reprogram_Pulse;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] Glitch_Count;
`endif

  input_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clock              (clock),
    .Reset              (Reset),
    .Sensor_Raw         (Sensor_Raw),
    .Walk_Request_Raw   (Walk_Request_Raw),
    .Reprogram_Raw      (Reprogram_Raw),
    .Sensor_Clean       (Sensor_Clean),
    .Walk_Request_Clean (Walk_Request_Clean),
    .Reprogram_Clean    (Reprogram_Clean),
    .Sensor_Pulse       (Sensor_Pulse),
    .Walk_Request_Pulse (Walk_Request_Pulse),
    .Reprogram_Pulse    (Reprogram_Pulse)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .Glitch_Count       (Glitch_Count)
`endif
  );

  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  string nm [3] = '{"sensor", "walk", "reprogram"};

  // Reference: two-sample input delay, then a level flips once D+1 consecutive
  // samples disagree with it; a disagreement run broken early is a glitch.
  bit m_s1 [3], m_s2 [3], m_clean [3], m_pulse [3];
  int m_run [3];
  int m_glitch;
  int dut_pulses [3];
  int mdl_pulses [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit [2:0] raw, input bit rst);
    int g;
    g = 0;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_s1[i] = 0; m_s2[i] = 0; m_clean[i] = 0; m_pulse[i] = 0; m_run[i] = 0;
      end else begin
        m_pulse[i] = 0;
        if (m_s2[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_clean[i] = m_s2[i];
            m_pulse[i] = m_s2[i];
            m_run[i]   = 0;
          end
        end else begin
          if (m_run[i] > 0) g++;
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
    if (rst) m_glitch = 0;
    else     m_glitch = (m_glitch + g > 255) ? 255 : m_glitch + g;
  endtask

  task automatic compare_all();
    logic [2:0] c, p;
    c = {Reprogram_Clean, Walk_Request_Clean, Sensor_Clean};
    p = {Reprogram_Pulse, Walk_Request_Pulse, Sensor_Pulse};
    for (int i = 0; i < 3; i++) begin
      check({nm[i], "_clean"}, 32'(c[i]), 32'(m_clean[i]));
      check({nm[i], "_pulse"}, 32'(p[i]), 32'(m_pulse[i]));
      if (p[i] === 1'b1) dut_pulses[i]++;
      if (m_pulse[i]) mdl_pulses[i]++;
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_count", 32'(Glitch_Count), 32'(m_glitch));
`endif
  endtask

  task automatic step(input bit [2:0] raw, input bit rst);
    Sensor_Raw       = raw[0];
    Walk_Request_Raw = raw[1];
    Reprogram_Raw    = raw[2];
    Reset            = rst;
    @(posedge clock);
    model_edge(raw, rst);
    #1;
    compare_all();
  endtask

  task automatic idle(input bit [2:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b0);
  endtask

  initial begin
    int p0, p_edge [3], g0, hold [3];
    bit [2:0] cur;

    for (int k = 0; k < 3; k++) step(3'b000, 1'b1);
    check("reset_walk_clean", 32'(Walk_Request_Clean), 32'd0);

    // clean press: walk first sampled at edge 10
    for (int e = 1; e <= 24; e++) begin
      step({1'b0, (e >= 10), 1'b0}, 1'b0);
      if (e == 19) check("press_clean_e19", 32'(Walk_Request_Clean), 32'd0);
      if (e == 20) check("press_pulse_e20", 32'(Walk_Request_Pulse), 32'd1);
      if (e == 20) check("press_clean_e20", 32'(Walk_Request_Clean), 32'd1);
      if (e == 21) check("press_pulse_e21", 32'(Walk_Request_Pulse), 32'd0);
    end
    idle(3'b000, 14);

    // sensor bounce: 5 x (3 high, 2 low)
    p0 = dut_pulses[0];
    g0 = m_glitch;
    for (int b = 0; b < 5; b++) begin
      idle(3'b001, 3);
      idle(3'b000, 2);
    end
    idle(3'b000, 12);
    check("bounce_pulses", 32'(dut_pulses[0] - p0), 32'd0);
    check("bounce_clean", 32'(Sensor_Clean), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("bounce_glitches", 32'(Glitch_Count), 32'(g0 + 5));
`endif

    // bouncy reprogram press then steady hold
    p0 = dut_pulses[2];
    for (int b = 0; b < 4; b++) begin
      idle(3'b100, 2);
      idle(3'b000, 2);
    end
    p_edge[2] = -1;
    for (int j = 0; j < 20; j++) begin
      step(3'b100, 1'b0);
      if (Reprogram_Pulse === 1'b1) p_edge[2] = j;
    end
    check("bouncy_pulses", 32'(dut_pulses[2] - p0), 32'd1);
    check("bouncy_latency", 32'(p_edge[2]), 32'd10);
    check("bouncy_clean", 32'(Reprogram_Clean), 32'd1);

    // release dip of 4 then a real release
    p0 = dut_pulses[2];
    idle(3'b000, 4);
    idle(3'b100, 14);
    check("dip_clean", 32'(Reprogram_Clean), 32'd1);
    check("dip_pulses", 32'(dut_pulses[2] - p0), 32'd0);
    for (int j = 0; j < 14; j++) begin
      step(3'b000, 1'b0);
      if (j == 9)  check("release_clean_j9", 32'(Reprogram_Clean), 32'd1);
      if (j == 10) check("release_clean_j10", 32'(Reprogram_Clean), 32'd0);
    end
    check("release_pulses", 32'(dut_pulses[2] - p0), 32'd0);

    // reset mid-debounce on walk (counter at 5)
    idle(3'b010, 8);
    step(3'b010, 1'b1);
    check("midreset_clean", 32'(Walk_Request_Clean), 32'd0);
    p0 = dut_pulses[1];
    for (int j = 1; j <= 14; j++) begin
      step(3'b010, 1'b0);
      if (j == 10) check("midreset_pulse_j10", 32'(Walk_Request_Pulse), 32'd0);
      if (j == 11) check("midreset_pulse_j11", 32'(Walk_Request_Pulse), 32'd1);
    end
    check("midreset_pulses", 32'(dut_pulses[1] - p0), 32'd1);
    idle(3'b000, 14);

    // simultaneous rise on all channels
    for (int i = 0; i < 3; i++) p_edge[i] = -1;
    for (int j = 0; j < 14; j++) begin
      step(3'b111, 1'b0);
      if (Sensor_Pulse === 1'b1)       p_edge[0] = j;
      if (Walk_Request_Pulse === 1'b1) p_edge[1] = j;
      if (Reprogram_Pulse === 1'b1)    p_edge[2] = j;
    end
    for (int i = 0; i < 3; i++) check({nm[i], "_simul_edge"}, 32'(p_edge[i]), 32'd10);
    idle(3'b000, 14);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    g0 = m_glitch;
    idle(3'b111, 2);
    idle(3'b000, 3);
    check("triple_glitch", 32'(Glitch_Count), 32'(g0 + 3));
    for (int b = 0; b < 90; b++) begin
      idle(3'b111, 2);
      idle(3'b000, 3);
    end
    check("glitch_saturate", 32'(Glitch_Count), 32'd255);
`endif

    // randomized hold lengths straddling the window, occasional reset
    cur = '0;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          cur[i]  = 1'($urandom_range(1, 0));
          hold[i] = $urandom_range(2 * D + 3, 1);
        end
        hold[i]--;
      end
      step(cur, ($urandom_range(499, 0) == 0));
    end

    for (int i = 0; i < 3; i++)
      check({nm[i], "_pulse_total"}, 32'(dut_pulses[i]), 32'(mdl_pulses[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
